// File: rtl/world_time_pkg.sv
// Shared types and constants for the multi-zone world clock converter.
// The optional half-hour zone support is enabled with WORLD_TIME_HALF_HOUR_EN.
package world_time_pkg;

    localparam int HOURS_PER_DAY = 24;
    localparam int MINS_PER_HOUR = 60;

    typedef logic [3:0]        bcd_t;
    typedef logic signed [5:0] offset_t;

    // Two's-complement day offset: -1, 0, +1.
    typedef enum logic [1:0] {
        DAY_SAME = 2'b00,
        DAY_NEXT = 2'b01,
        DAY_PREV = 2'b11
    } day_ofs_t;

    // Digit value shown when the input time is invalid.
    localparam bcd_t BCD_BLANK = 4'hF;

    // Four zones, zone 0 in the LSBs: 0, -9, -14, -17 hours.
    localparam logic [23:0] DEFAULT_OFFSET_TABLE = {-6'sd17, -6'sd14, -6'sd9, 6'sd0};

endpackage

// File: rtl/world_time_multi_if.sv
// Display-path bus of the world clock: home time in, zone time out.
// With WORLD_TIME_HALF_HOUR_EN the minute input and minute digits are added.
interface world_time_multi_if #(
    parameter int ZONE_W = 3
);
    logic [6:0]        HOUR;
    logic              W_SELECT;
    logic              AUTO;
    logic              TICK;
    logic [ZONE_W-1:0] W_COUNT;
    logic [3:0]        HOUR_W10;
    logic [3:0]        HOUR_W1;
    logic [1:0]        DAY_OFS;
    logic              HOUR_ERR;
`ifdef WORLD_TIME_HALF_HOUR_EN
    logic [5:0]        MIN;
    logic [3:0]        MIN_W10;
    logic [3:0]        MIN_W1;

    modport master (
        output HOUR, W_SELECT, AUTO, TICK, MIN,
        input  W_COUNT, HOUR_W10, HOUR_W1, DAY_OFS, HOUR_ERR, MIN_W10, MIN_W1
    );
    modport slave (
        input  HOUR, W_SELECT, AUTO, TICK, MIN,
        output W_COUNT, HOUR_W10, HOUR_W1, DAY_OFS, HOUR_ERR, MIN_W10, MIN_W1
    );
`else
    modport master (
        output HOUR, W_SELECT, AUTO, TICK,
        input  W_COUNT, HOUR_W10, HOUR_W1, DAY_OFS, HOUR_ERR
    );
    modport slave (
        input  HOUR, W_SELECT, AUTO, TICK,
        output W_COUNT, HOUR_W10, HOUR_W1, DAY_OFS, HOUR_ERR
    );
`endif
endinterface

// File: rtl/wt_bcd_split.sv
// Combinational binary (0..59) to two-digit BCD converter.
module wt_bcd_split
    import world_time_pkg::*;
(
    input  logic [5:0] bin_i,
    output bcd_t       tens_o,
    output bcd_t       ones_o
);

    logic [5:0] base;

    // Pick the tens digit by range, then the ones digit is the remainder.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every path, otherwise a latch is inferred.
        if (bin_i >= 6'd50) begin
            tens_o = 4'd5;
            base   = 6'd50;
        end else if (bin_i >= 6'd40) begin
            tens_o = 4'd4;
            base   = 6'd40;
        end else if (bin_i >= 6'd30) begin
            tens_o = 4'd3;
            base   = 6'd30;
        end else if (bin_i >= 6'd20) begin
            tens_o = 4'd2;
            base   = 6'd20;
        end else if (bin_i >= 6'd10) begin
            tens_o = 4'd1;
            base   = 6'd10;
        end else begin
            tens_o = 4'd0;
            base   = 6'd0;
        end
        ones_o = 4'(bin_i - base);
    end

endmodule

// File: rtl/world_time_multi.sv
// Multi-zone world clock converter: selects a zone (button or auto-scroll),
// adds its hour offset to the home hour and registers BCD digits plus a day offset.
// Optional half-hour zones and minute digits: define WORLD_TIME_HALF_HOUR_EN.
module world_time_multi
    import world_time_pkg::*;
#(
    parameter int                   N_ZONES      = 4,
    parameter int                   ZONE_W       = 3,
    parameter logic [6*N_ZONES-1:0] OFFSET_TABLE = DEFAULT_OFFSET_TABLE,
`ifdef WORLD_TIME_HALF_HOUR_EN
    parameter logic [N_ZONES-1:0]   HALF_MASK    = '0,
`endif
    parameter int                   SCROLL_TICKS = 5
) (
    input  logic              CLK,
    input  logic              RESET,
    world_time_multi_if.slave bus
);

    localparam logic [ZONE_W-1:0]  ZONE_LAST   = ZONE_W'(N_ZONES - 1);
    localparam logic [7:0]         SCROLL_LAST = 8'(SCROLL_TICKS - 1);
    localparam logic signed [7:0]  DAY_HOURS   = 8'(HOURS_PER_DAY);

    logic              sel_q;
    logic [7:0]        scroll_q, scroll_d;
    logic [ZONE_W-1:0] w_count_q, w_count_d;
    bcd_t              hour_w10_q, hour_w10_d;
    bcd_t              hour_w1_q, hour_w1_d;
    day_ofs_t          day_ofs_q, day_ofs_d;
    logic              hour_err_q, hour_err_d;

    logic              press;
    logic              roll;
    offset_t           off;
    logic              carry;
    logic signed [7:0] hour_s, ofs_s, carry_s, sum;
    logic [5:0]        hour_bin;
    bcd_t              hour_tens, hour_ones;

`ifdef WORLD_TIME_HALF_HOUR_EN
    bcd_t              min_w10_q, min_w10_d;
    bcd_t              min_w1_q, min_w1_d;
    logic              half;
    logic [6:0]        min_sum;
    logic [5:0]        min_bin;
    bcd_t              min_tens, min_ones;
`endif

    // One pulse per rising edge of the button; a scroll roll-over on the last tick.
    assign press = bus.W_SELECT & ~sel_q;
    assign roll  = bus.AUTO & bus.TICK & (scroll_q == SCROLL_LAST);

    // Zone index and scroll counter next state; press and roll together advance once.
    always_comb begin
        w_count_d = w_count_q;
        if (press || roll) begin
            w_count_d = (w_count_q == ZONE_LAST) ? '0 : w_count_q + 1'b1;
        end
        if (!bus.AUTO || press || roll) begin
            scroll_d = '0;
        end else if (bus.TICK) begin
            scroll_d = scroll_q + 8'd1;
        end else begin
            scroll_d = scroll_q;
        end
    end

`ifdef WORLD_TIME_HALF_HOUR_EN
    // Minute path: optional +30 min, carrying into the hour before the day wrap.
    always_comb begin
        half = 1'b0;
        for (int z = 0; z < N_ZONES; z++) begin
            if (w_count_q == ZONE_W'(z)) half = HALF_MASK[z];
        end
        min_sum = {1'b0, bus.MIN} + (half ? 7'd30 : 7'd0);
        if (min_sum >= 7'(MINS_PER_HOUR)) begin
            min_bin = 6'(min_sum - 7'(MINS_PER_HOUR));
            carry   = 1'b1;
        end else begin
            min_bin = 6'(min_sum);
            carry   = 1'b0;
        end
    end

    wt_bcd_split u_min_bcd (
        .bin_i  (min_bin),
        .tens_o (min_tens),
        .ones_o (min_ones)
    );
`else
    assign carry = 1'b0;
`endif

    // Hour path: signed sum of home hour and zone offset, wrapped into one day.
    always_comb begin
        off = '0;
        for (int z = 0; z < N_ZONES; z++) begin
            if (w_count_q == ZONE_W'(z)) off = offset_t'(OFFSET_TABLE[6*z +: 6]);
        end
        hour_s  = {1'b0, bus.HOUR};
        ofs_s   = {{2{off[5]}}, off};
        carry_s = {7'd0, carry};
        sum     = hour_s + ofs_s + carry_s;
        if (sum < 8'sd0) begin
            hour_bin  = 6'(sum + DAY_HOURS);
            day_ofs_d = DAY_PREV;
        end else if (sum >= DAY_HOURS) begin
            hour_bin  = 6'(sum - DAY_HOURS);
            day_ofs_d = DAY_NEXT;
        end else begin
            hour_bin  = 6'(sum);
            day_ofs_d = DAY_SAME;
        end

        hour_err_d = (bus.HOUR >= 7'(HOURS_PER_DAY));
`ifdef WORLD_TIME_HALF_HOUR_EN
        hour_err_d = hour_err_d | (bus.MIN >= 6'(MINS_PER_HOUR));
        min_w10_d  = min_tens;
        min_w1_d   = min_ones;
`endif
        hour_w10_d = hour_tens;
        hour_w1_d  = hour_ones;
        if (hour_err_d) begin
            hour_w10_d = BCD_BLANK;
            hour_w1_d  = BCD_BLANK;
            day_ofs_d  = DAY_SAME;
`ifdef WORLD_TIME_HALF_HOUR_EN
            min_w10_d  = BCD_BLANK;
            min_w1_d   = BCD_BLANK;
`endif
        end
    end

    wt_bcd_split u_hour_bcd (
        .bin_i  (hour_bin),
        .tens_o (hour_tens),
        .ones_o (hour_ones)
    );

    // State and output registers; reset wins over press and tick.
    always_ff @(posedge CLK) begin
        // NOTE: reset is sampled on the clock edge only, so it is tested inside the clocked block, not in the sensitivity list.
        if (RESET) begin
            sel_q      <= 1'b0;
            scroll_q   <= '0;
            w_count_q  <= '0;
            hour_w10_q <= '0;
            hour_w1_q  <= '0;
            day_ofs_q  <= DAY_SAME;
            hour_err_q <= 1'b0;
`ifdef WORLD_TIME_HALF_HOUR_EN
            min_w10_q  <= '0;
            min_w1_q   <= '0;
`endif
        end else begin
            // NOTE: clocked state uses non-blocking assignment so every register samples pre-edge values.
            sel_q      <= bus.W_SELECT;
            scroll_q   <= scroll_d;
            w_count_q  <= w_count_d;
            hour_w10_q <= hour_w10_d;
            hour_w1_q  <= hour_w1_d;
            day_ofs_q  <= day_ofs_d;
            hour_err_q <= hour_err_d;
`ifdef WORLD_TIME_HALF_HOUR_EN
            min_w10_q  <= min_w10_d;
            min_w1_q   <= min_w1_d;
`endif
        end
    end

    assign bus.W_COUNT  = w_count_q;
    assign bus.HOUR_W10 = hour_w10_q;
    assign bus.HOUR_W1  = hour_w1_q;
    assign bus.DAY_OFS  = day_ofs_q;
    assign bus.HOUR_ERR = hour_err_q;
`ifdef WORLD_TIME_HALF_HOUR_EN
    assign bus.MIN_W10  = min_w10_q;
    assign bus.MIN_W1   = min_w1_q;
`endif

endmodule

// File: doc/world_time_multi.md
Name: world_time_multi

Overview:
Parametrised multi-zone world clock converter for the clock display path. Takes home-time hour (binary, 0-23) and produces a selected zone's local hour as BCD tens/ones plus a day-offset indicator. Zone selection comes from a debounced push button (internal edge detector) or from an automatic scroll mode. Sits between the timekeeping core and the 7-segment display mux.

Parameters:
N_ZONES, 4, number of selectable zones (2..8)
ZONE_W, 3, width of zone index; must satisfy 2**ZONE_W >= N_ZONES
OFFSET_TABLE, {-6'sd17,-6'sd14,-6'sd9,6'sd0}, packed signed 6-bit hour offset per zone; zone 0 in the LSBs; legal range -23..+23
SCROLL_TICKS, 5, TICK pulses per zone advance in auto mode (1..255)

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
HOUR  in  7  home hour, binary
W_SELECT  in  1  debounced button level, synchronous to CLK
AUTO  in  1  1 = auto-scroll zones, 0 = manual
TICK  in  1  single-cycle 1 Hz strobe
W_COUNT  out  ZONE_W  current zone index
HOUR_W10  out  4  BCD tens of zone hour
HOUR_W1  out  4  BCD ones of zone hour
DAY_OFS  out  2  signed day offset: 2'b11 = -1, 2'b00 = 0, 2'b01 = +1
HOUR_ERR  out  1  HOUR input out of range

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high on RESET. All state updates on posedge CLK.
- Reset values: W_COUNT=0, HOUR_W10=0, HOUR_W1=0, DAY_OFS=0, HOUR_ERR=0, scroll counter=0, edge-detect register=0.
- Edge detect: sel_q registers W_SELECT. A press is W_SELECT & ~sel_q, giving one pulse per rising edge. Holding the button produces no repeats.
- Manual mode (AUTO=0):
  - A press advances W_COUNT by 1.
  - At W_COUNT=N_ZONES-1 a press wraps W_COUNT to 0.
  - W_COUNT never holds a value >= N_ZONES.
- Auto mode (AUTO=1):
  - Each TICK increments the scroll counter.
  - When the counter reaches SCROLL_TICKS-1 and TICK=1, the counter clears and W_COUNT advances with the same wrap rule.
- Simultaneous press and scroll advance in the same cycle: W_COUNT advances by exactly 1 and the scroll counter clears.
- A press in auto mode still advances W_COUNT and clears the scroll counter.
- An AUTO 1->0 transition clears the scroll counter. W_COUNT is held.
- Arithmetic:
  - sum = HOUR + OFFSET_TABLE[W_COUNT], evaluated signed on 8 bits.
  - sum < 0: hour = sum + 24, DAY_OFS = -1.
  - sum >= 24: hour = sum - 24, DAY_OFS = +1.
  - Otherwise: hour = sum, DAY_OFS = 0.
- BCD: hour is split into tens (0..2) and ones (0..9).
- Out-of-range input: if HOUR >= 24, HOUR_ERR=1, HOUR_W10=HOUR_W1=4'hF and DAY_OFS=0.
- Latency:
  - Outputs are registered. HOUR_W10, HOUR_W1, DAY_OFS and HOUR_ERR reflect the HOUR and W_COUNT values present at the previous edge, i.e. 1 cycle after a change.
  - After a press, W_COUNT updates 1 cycle after the rising edge of W_SELECT. The digits follow 1 cycle later.
- Reset mid-operation: RESET overrides press and TICK in the same cycle. All state returns to reset values on that edge.

Optional Feature:
Macro WORLD_TIME_HALF_HOUR_EN.
- Defined:
  - Adds parameter HALF_MASK (N_ZONES bits; bit z=1 adds +30 min to zone z).
  - Adds input MIN (6, binary 0-59) and outputs MIN_W10 and MIN_W1 (4 each, BCD).
  - Minute sum >= 60 subtracts 60 and carries +1 into the hour sum before the day wrap.
  - MIN >= 60 also raises HOUR_ERR and drives 4'hF on all four digits.
  - Minute outputs reset to 0 and share the 1-cycle output latency.
- Undefined: no MIN, MIN_W10, MIN_W1 ports and no HALF_MASK. Behaviour is exactly as above.

Decomposition:
- Shared package world_time_pkg:
  - HOURS_PER_DAY=24 and MINS_PER_HOUR=60.
  - Day-offset encodings DAY_PREV, DAY_SAME, DAY_NEXT.
  - Typedefs bcd_t (4-bit), offset_t (signed 6-bit) and day_ofs_t (2-bit).
  - Default offset-table constant.
- One natural sub-module: wt_bcd_split, a combinational binary 0..59 to BCD tens/ones converter. It is instantiated once for the hour and once for the minute when the macro is defined.

Test Plan:
- Reset, then HOUR=10, AUTO=0, no press -> W_COUNT=0, HOUR_W10=1, HOUR_W1=0, DAY_OFS=0 one cycle after reset release.
- HOUR=5, one press -> W_COUNT=1 (offset -9), HOUR_W10=2, HOUR_W1=0, DAY_OFS=2'b11.
- HOUR=23, zone 0, then 4 presses -> W_COUNT sequence 1,2,3,0 (wraps).
- Hold W_SELECT high for 10 cycles -> W_COUNT advances once only.
- AUTO=1, SCROLL_TICKS=5, 10 TICK pulses -> W_COUNT advances on the 5th and 10th TICK only. A press coincident with the 5th TICK -> single advance and scroll counter cleared.
- HOUR=24 -> HOUR_ERR=1, digits 4'hF. Assert RESET mid-scroll -> all outputs 0 on the next edge.
